// File: rtl/exe_mdu_iter.sv
// exe_mdu_iter: iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
// Multiply is shift-add and retires MUL_STEP multiplier bits per cycle.
// Divide is restoring and produces one quotient bit per cycle.
// Divide-by-zero, signed overflow and (optionally) zero-operand multiplies
// complete through a one-cycle fast path.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous reset, active-low
//   start_i   M instruction present in execute (level); sampled only in IDLE
//   flush_i   abort the current op
//   funct3_i  M op select
//   op1_i     rs1 value
//   op2_i     rs2 value
//   result_o  result; valid with done_o, held until the next accepted start
//   done_o    one-cycle completion pulse
//   busy_o    high while an op is in flight (MUL/DIV/DONE)
//   stall_o   combinational pipeline stall request
module exe_mdu_iter #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_STEP    = 4,
  parameter bit          ZERO_BYPASS = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            stall_o
);

  localparam int unsigned CW      = $clog2(XLEN + 1);
  localparam int unsigned PW      = 2 * XLEN;
  localparam int unsigned MUL_CYC = XLEN / MUL_STEP;
  localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state, state_n;
  logic [2:0]      op, op_n;
  logic            neg, neg_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [PW-1:0]   acc, acc_n;      // product accumulator
  logic [PW-1:0]   mc, mc_n;        // multiplicand, shifted left each MUL cycle
  logic [XLEN-1:0] mp, mp_n;        // multiplier (MUL) or dividend/quotient (DIV)
  logic [XLEN-1:0] rem, rem_n;      // partial remainder
  logic [XLEN-1:0] dvs, dvs_n;      // divisor magnitude
  logic [XLEN-1:0] result_n;
  logic            done_n, busy_n;

  // Operand decode for the start cycle
  logic            sgn1, sgn2, neg1, neg2, res_neg, fast;
  logic [XLEN-1:0] mag1, mag2, fast_res;

  // Per-cycle datapath results
  logic [PW-1:0]   pp, acc_sum, prod;
  logic [XLEN:0]   tmp;
  logic            ge;
  logic [XLEN-1:0] diff, rem_step, q_step;

  assign stall_o = start_i & ~done_o & ~flush_i;

  // Signedness, magnitudes, result sign and fast-path detection
  always_comb begin
    sgn1 = (funct3_i == 3'd1) | (funct3_i == 3'd2) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
    sgn2 = (funct3_i == 3'd1) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
    neg1 = sgn1 & op1_i[XLEN-1];
    neg2 = sgn2 & op2_i[XLEN-1];
    mag1 = neg1 ? (~op1_i + XLEN'(1)) : op1_i;
    mag2 = neg2 ? (~op2_i + XLEN'(1)) : op2_i;
    // Remainder takes the dividend's sign; everything else the xor of signs
    res_neg  = (funct3_i[2] & funct3_i[1]) ? neg1 : (neg1 ^ neg2);
    fast     = 1'b0;
    fast_res = '0;
    if (funct3_i[2]) begin
      if (op2_i == '0) begin
        fast     = 1'b1;
        fast_res = funct3_i[1] ? op1_i : '1;
      end else if (!funct3_i[0] && (op1_i == MIN_S) && (op2_i == '1)) begin
        fast     = 1'b1;
        fast_res = funct3_i[1] ? '0 : MIN_S;
      end
    end else if (ZERO_BYPASS && ((op1_i == '0) || (op2_i == '0))) begin
      fast     = 1'b1;
      fast_res = '0;
    end
  end

  // One multiply step and one restoring-divide step
  always_comb begin
    pp = '0;
    for (int i = 0; i < int'(MUL_STEP); i++) begin
      if (mp[i]) pp = pp + (mc << i);
    end
    acc_sum  = acc + pp;
    prod     = neg ? (~acc_sum + PW'(1)) : acc_sum;
    tmp      = {rem, mp[XLEN-1]};
    ge       = (tmp >= {1'b0, dvs});
    // When ge the true difference is below 2^XLEN, so the low bits suffice
    diff     = tmp[XLEN-1:0] - dvs;
    rem_step = ge ? diff : tmp[XLEN-1:0];
    q_step   = {mp[XLEN-2:0], ge};
  end

  // Next-state and register update logic
  always_comb begin
    state_n  = state;
    op_n     = op;
    neg_n    = neg;
    cnt_n    = cnt;
    acc_n    = acc;
    mc_n     = mc;
    mp_n     = mp;
    rem_n    = rem;
    dvs_n    = dvs;
    result_n = result_o;
    case (state)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_n  = funct3_i;
          neg_n = res_neg;
          acc_n = '0;
          mc_n  = PW'(mag1);
          mp_n  = funct3_i[2] ? mag1 : mag2;
          rem_n = '0;
          dvs_n = mag2;
          if (fast) begin
            result_n = fast_res;
            state_n  = S_DONE;
          end else if (funct3_i[2]) begin
            state_n = S_DIV;
            cnt_n   = CW'(XLEN);
          end else begin
            state_n = S_MUL;
            cnt_n   = CW'(MUL_CYC);
          end
        end
      end
      S_MUL: begin
        acc_n = acc_sum;
        mc_n  = mc << MUL_STEP;
        mp_n  = mp >> MUL_STEP;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n  = S_DONE;
          result_n = (op == 3'd0) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
        end
      end
      S_DIV: begin
        rem_n = rem_step;
        mp_n  = q_step;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = S_DONE;
          if (op[1]) result_n = neg ? (~rem_step + XLEN'(1)) : rem_step;
          else       result_n = neg ? (~q_step + XLEN'(1)) : q_step;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // An aborted op never completes and leaves the previous result visible
    if (flush_i) begin
      state_n  = S_IDLE;
      result_n = result_o;
    end
    done_n = (state_n == S_DONE);
    busy_n = (state_n != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      op       <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mc       <= '0;
      mp       <= '0;
      rem      <= '0;
      dvs      <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_n;
      op       <= op_n;
      neg      <= neg_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      mc       <= mc_n;
      mp       <= mp_n;
      rem      <= rem_n;
      dvs      <= dvs_n;
      result_o <= result_n;
      done_o   <= done_n;
      busy_o   <= busy_n;
    end
  end

endmodule

// File: tb/tb_exe_mdu_iter.sv
// Testbench for exe_mdu_iter: directed vector table, hand-written flush/reset
// and back-to-back sequences, and random ops checked against a plain
// arithmetic reference model. A second instance runs with ZERO_BYPASS=0.
module tb_exe_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_nb = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [31:0] result, result_nb;
  logic        done, busy, stall, done_nb, busy_nb, stall_nb;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exe_mdu_iter #(.XLEN(32), .MUL_STEP(4), .ZERO_BYPASS(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush),
    .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
    .result_o(result), .done_o(done), .busy_o(busy), .stall_o(stall)
  );

  exe_mdu_iter #(.XLEN(32), .MUL_STEP(4), .ZERO_BYPASS(1'b0)) dut_nb (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_nb), .flush_i(flush),
    .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
    .result_o(result_nb), .done_o(done_nb), .busy_o(busy_nb), .stall_o(stall_nb)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    int          ia, ib;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: return a * b;
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Expected cycle of done_o, counting the start cycle as 0
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit zb);
    if (f[2]) begin
      if (b == 32'd0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (zb && (a == 32'd0 || b == 32'd0)) return 1;
    return 9;
  endfunction

  // Issue one op and follow it to done_o, checking stall/busy every cycle.
  // Returns one cycle after done_o with start dropped.
  task automatic run_op(input bit nb, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    bit   stall_ok, busy_ok;
    logic d, s, bz;
    funct3 = f; op1 = a; op2 = b;
    if (nb) start_nb = 1'b1; else start = 1'b1;
    lat = -1; res = '0; stall_ok = 1'b1; busy_ok = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      d  = nb ? done_nb : done;
      s  = nb ? stall_nb : stall;
      bz = nb ? busy_nb : busy;
      if (d) begin
        lat = cyc;
        res = nb ? result_nb : result;
        if (s !== 1'b0) stall_ok = 1'b0;
        if (bz !== 1'b1) busy_ok = 1'b0;
      end else begin
        if (s !== 1'b1) stall_ok = 1'b0;
        if (bz !== (cyc > 0)) busy_ok = 1'b0;
      end
      @(posedge clk); #1;
      if (d) break;
    end
    start = 1'b0; start_nb = 1'b0;
    chk("stall_pattern", 64'(stall_ok), 64'd1);
    chk("busy_pattern", 64'(busy_ok), 64'd1);
  endtask

  // Cycle after done_o: unit must be back in IDLE
  task automatic idle_check(input string name);
    @(negedge clk);
    chk(name, {62'd0, busy, done}, 64'd0);
    @(posedge clk); #1;
  endtask

  vec_t        tv[13];
  logic [31:0] res, a, b;
  logic [2:0]  f;
  int          lat, ndone;
  bit          nb;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    tv[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 9};
    tv[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 9};
    tv[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 9};
    tv[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 9};
    tv[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    tv[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    tv[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    tv[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    tv[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    tv[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    tv[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tv[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    tv[12] = '{3'd0, 32'd0,          32'h1234,      32'd0,         1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {29'd0, result, done, busy, stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run_op(1'b0, tv[i].f, tv[i].a, tv[i].b, res, lat);
      chk($sformatf("tv%0d_result", i), 64'(res), 64'(tv[i].exp));
      chk($sformatf("tv%0d_latency", i), 64'(lat), 64'(tv[i].lat));
      idle_check($sformatf("tv%0d_idle", i));
    end

    // Zero operand without bypass goes through the full multiply
    run_op(1'b1, 3'd0, 32'd0, 32'h1234, res, lat);
    chk("nobypass_result", 64'(res), 64'd0);
    chk("nobypass_latency", 64'(lat), 64'd9);

    // Flush mid-divide: no done_o, result held, new MUL accepted afterwards
    run_op(1'b0, 3'd5, 32'd100, 32'd7, res, lat);
    chk("pre_flush_result", 64'(res), 64'd14);
    funct3 = 3'd4; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc == 4) flush = 1'b1;
      @(negedge clk);
      chk("flush_no_done", 64'(done), 64'd0);
      if (cyc == 4) chk("flush_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {62'd0, busy, done}, 64'd0);
    chk("flush_result_held", 64'(result), 64'd14);
    @(posedge clk); #1;
    run_op(1'b0, 3'd0, 32'd3, 32'd5, res, lat);
    chk("after_flush_result", 64'(res), 64'd15);
    chk("after_flush_latency", 64'(lat), 64'd9);

    // Flush in IDLE blocks acceptance
    funct3 = 3'd5; op1 = 32'd9; op2 = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_blocked", {62'd0, busy, done}, 64'd0);
    @(posedge clk); #1;

    // Flush coinciding with done_o: the pulse still appears
    funct3 = 3'd5; op1 = 32'd5; op2 = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_done_pulse", 64'(done), 64'd1);
    chk("flush_done_result", 64'(result), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    idle_check("flush_done_idle");

    // Back-to-back: second op starts in the cycle after done_o
    run_op(1'b0, 3'd0, 32'd6, 32'd7, res, lat);
    chk("b2b_first", 64'(res), 64'd42);
    run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 32'd2, res, lat);
    chk("b2b_second", 64'(res), 64'hFFFF_FFFF);
    chk("b2b_second_latency", 64'(lat), 64'd9);

    // Reset in cycle 3 of a multiply
    funct3 = 3'd0; op1 = 32'd9; op2 = 32'd9; start = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("midop_reset", {29'd0, result, done, busy, 1'b0}, 64'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_reset", 64'(ndone), 64'd0);
    @(posedge clk); #1;

    // Random ops against the reference model, issued back to back
    for (int k = 0; k < 80; k++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      nb = (k % 4 == 3);
      run_op(nb, f, a, b, res, lat);
      chk($sformatf("rand%0d_f%0d_%h_%h", k, f, a, b), 64'(res), 64'(ref_res(f, a, b)));
      chk($sformatf("rand%0d_latency", k), 64'(lat), 64'(ref_lat(f, a, b, !nb)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_mdu_iter.md
Name: exe_mdu_iter

Overview:
Parametrised iterative RV32M/RV64M multiply/divide unit for the execute stage. It handles all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Multiply is shift-add, processing MUL_STEP multiplier bits per cycle.
- Divide is restoring, one quotient bit per cycle.
- It requests a pipeline stall while an M instruction sits in execute and returns a one-cycle done-qualified result. It supports flush/abort and a zero-operand bypass.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
MUL_STEP, 4, multiplier bits retired per MUL cycle; must divide XLEN (1, 2, 4, 8).
ZERO_BYPASS, 1, when 1, a multiply with either operand equal to 0 completes in the fast path.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-low
start_i  in  1  M instruction present in execute (level); sampled only in IDLE
flush_i  in  1  abort current op (branch/exception kill)
funct3_i  in  3  M op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op1_i  in  XLEN  rs1 value
op2_i  in  XLEN  rs2 value
result_o  out  XLEN  result; valid when done_o=1, held until next accepted start
done_o  out  1  one-cycle completion pulse
busy_o  out  1  high in MUL/DIV/DONE states
stall_o  out  1  combinational: start_i & ~done_o & ~flush_i

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - State goes to IDLE.
  - result_o, done_o, busy_o, the counter and all datapath registers go to 0.
  - Reset dominates start_i and flush_i, including mid-operation.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1 and flush_i=0 (call this cycle 0):
  - Latch funct3 and operand magnitudes. Signed ops take the absolute value of operands treated as signed (MULHSU: op1 only). Latch the result sign.
  - Fast path, next state DONE with the result pre-computed:
    - DIV/DIVU with op2=0 → quotient all-ones.
    - REM/REMU with op2=0 → op1.
    - DIV with op1=min-signed and op2=-1 → min-signed.
    - REM with the same operands → 0.
    - ZERO_BYPASS=1 and a MUL* op with op1=0 or op2=0 → 0.
  - Otherwise next state is MUL (funct3<4) or DIV, and the counter is loaded.
- MUL:
  - Each cycle, add the partial products of the next MUL_STEP multiplier LSBs into a 2*XLEN accumulator, then shift.
  - Runs XLEN/MUL_STEP cycles, then goes to DONE.
  - Negate the 2*XLEN product if the sign flag is set.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- DIV:
  - Restoring algorithm over XLEN cycles, then DONE.
  - Quotient sign = sign(op1) xor sign(op2). Remainder sign = sign(op1).
- DONE:
  - done_o=1 and result_o is valid. Lasts exactly one cycle; next state IDLE.
  - stall_o=0 in this cycle, so the pipeline advances on this edge.
  - A start_i seen in the following IDLE cycle is a new instruction.
- Latency, with cycle 0 the IDLE start cycle:
  - done_o in cycle 1 for the fast path.
  - done_o in cycle XLEN/MUL_STEP+1 for multiply (9 at defaults).
  - done_o in cycle XLEN+1 for divide (33).
- flush_i:
  - In any state, next state is IDLE; no done_o for the aborted op; result_o is held.
  - flush_i in IDLE blocks acceptance of start_i.
  - flush_i and done_o in the same cycle: done_o still pulses (the result is already complete); the pipeline discards it.
- start_i and funct3_i/op changes while busy are ignored; operands come only from the latched copies.
- Arithmetic: all internal adders are XLEN+1 (divide) or 2*XLEN (multiply) bits wide. No overflow is flagged.

Test Plan:
1. MUL op1=7, op2=0xFFFFFFFD (-3) → result_o=0xFFFFFFEB. done_o only in cycle 9; stall_o=1 in cycles 0–8, 0 in cycle 9; busy_o=0 in cycle 10.
2. MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. Each done in cycle 9.
3. DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD and REM → 0xFFFFFFFF, done in cycle 33. DIVU 100/7 → 14 and REMU → 2.
4. Fast path, each done in cycle 1:
   - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
   - MUL 0×0x1234 → 0 (ZERO_BYPASS=1); with ZERO_BYPASS=0 the same op → 0 in cycle 9.
5. Abort and back-to-back:
   - DIV started, flush_i=1 in cycle 4 → IDLE in cycle 5, no done_o, result_o unchanged. A new MUL 3×5 started in cycle 6 → 15 in cycle 15.
   - Back-to-back MULs: the second starts in the cycle after done_o.
6. Reset: rst_i=0 in cycle 3 of a MUL → on the next edge state=IDLE and done_o, busy_o, result_o=0. No done_o afterwards until a new start.
